unidade_controle_multiciclo: RTL

Multicycle control FSM for the RV64 datapath. Decodes opcode/funct fields from the instruction register and drives every load enable, mux select and ALU operation of the datapath, one state per clock. Sits directly upstream of the datapath: the datapath consumes all of this block's outputs and returns only instruction fields and the ALU Zero flag.

---
 rtl/unidade_controle_multiciclo_if.sv | 37 +++
 rtl/unidade_controle_multiciclo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo_if.sv
// Control/datapath bundle for the RV64 multicycle core: instruction fields and
// Zero flow from the datapath (slave) to the control unit (master), enables flow back.
interface unidade_controle_multiciclo_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       PCwrite;
  logic       PCSrc;
  logic       IRwrite;
  logic       DMemWr;
  logic       loadMDR;
  logic       RegWrite;
  logic [1:0] MemToReg;
  logic       loadRegA;
  logic       loadRegB;
  logic       loadALUOut;
  logic       SelMux2;
  logic [1:0] SelMux4;
  logic [2:0] AluOperation;
  logic [3:0] state_out;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, Zero,
    output PCwrite, PCSrc, IRwrite, DMemWr, loadMDR, RegWrite, MemToReg,
           loadRegA, loadRegB, loadALUOut, SelMux2, SelMux4, AluOperation,
           state_out, illegal
  );

  modport slave (
    output opcode, funct3, funct7, Zero,
    input  PCwrite, PCSrc, IRwrite, DMemWr, loadMDR, RegWrite, MemToReg,
           loadRegA, loadRegB, loadALUOut, SelMux2, SelMux4, AluOperation,
           state_out, illegal
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RV64 datapath (add, sub, addi, ld, sd, beq, bne, lui).
// Optional macro ILLEGAL_TRAP_EN: unsupported opcode / funct3 in DECODE locks into TRAP.
module unidade_controle_multiciclo (
  input logic                          clk,
  input logic                          rst,
  unidade_controle_multiciclo_if.master bus
);
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BNE  = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,  S_FETCH = 4'd1,    S_FETCH_WAIT = 4'd2, S_DECODE = 4'd3,
    S_EXEC_R = 4'd4, S_EXEC_I = 4'd5,   S_WB_ALU = 4'd6,     S_MEM_ADDR = 4'd7,
    S_LD_READ = 4'd8, S_LD_WB = 4'd9,   S_SD_WRITE = 4'd10,  S_BRANCH = 4'd11,
    S_PC_INC = 4'd12, S_LUI_WB = 4'd13, S_TRAP = 4'd14,      S_UNUSED = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcsrc;
    logic       irwrite;
    logic       dmemwr;
    logic       loadmdr;
    logic       regwrite;
    logic [1:0] memtoreg;
    logic       loada;
    logic       loadb;
    logic       loadaluout;
    logic       selmux2;
    logic [1:0] selmux4;
    logic [2:0] aluop;
    logic       illegal;
  } ctrl_t;

  state_t state, nxt, dec_next;
  ctrl_t  ctrl_q;
  logic   br_taken;

  // Moore output table; the branch redirect is added combinationally below.
  function automatic ctrl_t moore(input state_t s, input logic [6:0] f7);
    ctrl_t c;
    logic  pc_step;
    c       = '0;
    pc_step = 1'b0;
    case (s)
      S_FETCH_WAIT: c.irwrite = 1'b1;
      S_DECODE: begin
        c.loada = 1'b1; c.loadb = 1'b1; c.loadaluout = 1'b1;
        c.selmux4 = 2'b11; c.aluop = ALU_ADD;
      end
      S_EXEC_R: begin
        c.selmux2 = 1'b1; c.loadaluout = 1'b1;
        c.aluop = (f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.selmux2 = 1'b1; c.selmux4 = 2'b10; c.aluop = ALU_ADD; c.loadaluout = 1'b1;
      end
      S_WB_ALU:   begin c.regwrite = 1'b1; pc_step = 1'b1; end
      S_LD_READ:  c.loadmdr = 1'b1;
      S_LD_WB:    begin c.regwrite = 1'b1; c.memtoreg = 2'b01; pc_step = 1'b1; end
      S_SD_WRITE: begin c.dmemwr = 1'b1; pc_step = 1'b1; end
      S_BRANCH:   begin c.selmux2 = 1'b1; c.aluop = ALU_SUB; end
      S_PC_INC:   pc_step = 1'b1;
      S_LUI_WB:   begin c.regwrite = 1'b1; c.memtoreg = 2'b10; pc_step = 1'b1; end
      S_TRAP:     c.illegal = 1'b1;
      default:    c.aluop = ALU_PASS;
    endcase
    if (pc_step) begin
      c.selmux2 = 1'b0; c.selmux4 = 2'b01; c.aluop = ALU_ADD;
      c.pcsrc = 1'b0; c.pcwrite = 1'b1;
    end
    return c;
  endfunction

  assign br_taken = (bus.opcode == OP_BEQ &&  bus.Zero) ||
                    (bus.opcode == OP_BNE && !bus.Zero);

  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    dec_next = S_PC_INC;
    case (bus.opcode)
      OP_R:           dec_next = S_EXEC_R;
      OP_I:           dec_next = S_EXEC_I;
      OP_LD, OP_SD:   dec_next = S_MEM_ADDR;
      OP_BEQ, OP_BNE: dec_next = S_BRANCH;
      OP_LUI:         dec_next = S_LUI_WB;
      default:        dec_next = S_PC_INC;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic f3_ok;
  always_comb begin
    f3_ok = 1'b0;
    case (bus.opcode)
      OP_R, OP_I, OP_BEQ: f3_ok = (bus.funct3 == 3'b000);
      OP_LD:              f3_ok = (bus.funct3 == 3'b011);
      OP_SD:              f3_ok = (bus.funct3 == 3'b111);
      OP_BNE:             f3_ok = (bus.funct3 == 3'b001);
      OP_LUI:             f3_ok = 1'b1;
      default:            f3_ok = 1'b0;
    endcase
  end
`endif

  always_comb begin
    nxt = S_RESET;
    case (state)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: nxt = S_DECODE;
`ifdef ILLEGAL_TRAP_EN
      S_DECODE:     nxt = f3_ok ? dec_next : S_TRAP;
      S_TRAP:       nxt = S_TRAP;
`else
      S_DECODE:     nxt = dec_next;
      S_TRAP:       nxt = S_RESET;
`endif
      S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
      S_MEM_ADDR:   nxt = (bus.opcode == OP_LD) ? S_LD_READ : S_SD_WRITE;
      S_LD_READ:    nxt = S_LD_WB;
      S_BRANCH:     nxt = br_taken ? S_FETCH : S_PC_INC;
      S_WB_ALU, S_LD_WB, S_SD_WRITE, S_PC_INC, S_LUI_WB: nxt = S_FETCH;
      default:      nxt = S_RESET;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RESET;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= moore(nxt, bus.funct7);
    end
  end

  assign bus.PCwrite      = ctrl_q.pcwrite | (state == S_BRANCH && br_taken);
  assign bus.PCSrc        = ctrl_q.pcsrc   | (state == S_BRANCH && br_taken);
  assign bus.IRwrite      = ctrl_q.irwrite;
  assign bus.DMemWr       = ctrl_q.dmemwr;
  assign bus.loadMDR      = ctrl_q.loadmdr;
  assign bus.RegWrite     = ctrl_q.regwrite;
  assign bus.MemToReg     = ctrl_q.memtoreg;
  assign bus.loadRegA     = ctrl_q.loada;
  assign bus.loadRegB     = ctrl_q.loadb;
  assign bus.loadALUOut   = ctrl_q.loadaluout;
  assign bus.SelMux2      = ctrl_q.selmux2;
  assign bus.SelMux4      = ctrl_q.selmux4;
  assign bus.AluOperation = ctrl_q.aluop;
  assign bus.state_out    = state;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal      = ctrl_q.illegal;
`else
  assign bus.illegal      = 1'b0;
`endif
endmodule
